// File: rtl/alu_if.sv
// Operand/result bundle for the registered Hack-style ALU.
// The master drives operands and control; the slave returns the registered result and flags.
interface alu_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [5:0]       opr;
    logic             in_valid;
    logic [WIDTH-1:0] out;
    logic             zr;
    logic             ng;
    logic             out_valid;

    modport master (
        output a, b, opr, in_valid,
        input  out, zr, ng, out_valid
    );

    modport slave (
        input  a, b, opr, in_valid,
        output out, zr, ng, out_valid
    );
endinterface

// File: rtl/alu.sv
// Registered Hack-style ALU: zx/nx/zy/ny/f/no datapath with a one-cycle result,
// zero/negative flags computed from the same result and registered alongside it.
module alu #(
    parameter int unsigned WIDTH = 16
) (
    input logic   clk,
    input logic   rst,
    alu_if.slave  bus
);
    logic zx, nx, zy, ny, fn, no;
    logic [WIDTH-1:0] x1, x2, y1, y2, r, res;

    logic [WIDTH-1:0] out_q, out_d;
    logic             zr_q, zr_d;
    logic             ng_q, ng_d;
    logic             out_valid_q;

    always_comb begin
        {zx, nx, zy, ny, fn, no} = bus.opr;
        x1  = zx ? '0 : bus.a;
        x2  = nx ? ~x1 : x1;
        y1  = zy ? '0 : bus.b;
        y2  = ny ? ~y1 : y1;
        // Carry-out is dropped: the sum wraps modulo 2^WIDTH.
        r   = fn ? (x2 + y2) : (x2 & y2);
        res = no ? ~r : r;
    end

    always_comb begin
        out_d = out_q;
        zr_d  = zr_q;
        ng_d  = ng_q;
        if (bus.in_valid) begin
            out_d = res;
            zr_d  = (res == '0);
            ng_d  = res[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            zr_q        <= 1'b1;
            ng_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            zr_q        <= zr_d;
            ng_q        <= ng_d;
            out_valid_q <= bus.in_valid;
        end
    end

    assign bus.out       = out_q;
    assign bus.zr        = zr_q;
    assign bus.ng        = ng_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: a function-level reference model checked every cycle,
// plus literal expectations for each directed vector, hold and reset behaviour.
module tb_alu;
    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_if #(.WIDTH(W)) bus ();

    alu #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: what each canonical control word means, in plain arithmetic.
    function automatic logic [W-1:0] ref_fn(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic [5:0] op);
        logic [W-1:0] v;
        case (op)
            6'b101010: v = 0;
            6'b111111: v = 1;
            6'b111010: v = -1;
            6'b001100: v = x;
            6'b110000: v = y;
            6'b001101: v = ~x;
            6'b110001: v = ~y;
            6'b001111: v = -x;
            6'b110011: v = -y;
            6'b011111: v = x + 1;
            6'b110111: v = y + 1;
            6'b001110: v = x - 1;
            6'b110010: v = y - 1;
            6'b000010: v = x + y;
            6'b010011: v = x - y;
            6'b000111: v = y - x;
            6'b000000: v = x & y;
            6'b010101: v = x | y;
            default:   v = 'x;
        endcase
        return v;
    endfunction

    logic [W-1:0] m_out;
    logic         m_zr, m_ng, m_valid;
    bit           armed = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_out   <= '0;
            m_zr    <= 1'b1;
            m_ng    <= 1'b0;
            m_valid <= 1'b0;
            armed   <= 1'b1;
        end else begin
            m_valid <= bus.in_valid;
            if (bus.in_valid) begin
                m_out <= ref_fn(bus.a, bus.b, bus.opr);
                m_zr  <= (ref_fn(bus.a, bus.b, bus.opr) == 0);
                m_ng  <= ($signed(ref_fn(bus.a, bus.b, bus.opr)) < 0);
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("model.out_valid", 32'(bus.out_valid), 32'(m_valid));
            chk("model.out", 32'(bus.out), 32'(m_out));
            chk("model.zr", 32'(bus.zr), 32'(m_zr));
            chk("model.ng", 32'(bus.ng), 32'(m_ng));
        end
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [5:0]   op;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [5:0] op, input logic [W-1:0] exp);
        vec_t v;
        v.a = a; v.b = b; v.op = op; v.exp = exp;
        vecs.push_back(v);
    endfunction

    initial begin
        add(16'd112, 16'd310, 6'b101010, 16'h0000);
        add(16'd112, 16'd310, 6'b111111, 16'h0001);
        add(16'd112, 16'd310, 6'b111010, 16'hFFFF);
        add(16'd112, 16'd310, 6'b001100, 16'd112);
        add(16'd112, 16'd310, 6'b110000, 16'd310);
        add(16'd112, 16'd310, 6'b001101, 16'hFF8F);
        add(16'd112, 16'd310, 6'b110001, 16'hFEC9);
        add(16'd112, 16'd310, 6'b001111, 16'hFF90);
        add(16'd112, 16'd310, 6'b110011, 16'hFECA);
        add(16'd112, 16'd310, 6'b011111, 16'd113);
        add(16'd112, 16'd310, 6'b110111, 16'd311);
        add(16'd112, 16'd310, 6'b001110, 16'd111);
        add(16'd112, 16'd310, 6'b110010, 16'd309);
        add(16'd112, 16'd310, 6'b000010, 16'd422);
        add(16'd112, 16'd310, 6'b010011, 16'hFF3A);
        add(16'd112, 16'd310, 6'b000111, 16'd198);
        add(16'd112, 16'd310, 6'b000000, 16'd48);
        add(16'd112, 16'd310, 6'b010101, 16'd374);
        // a = -112 (0xFF90), b = 310: x|y = x+y-(x&y) = 198-272 = -74.
        add(16'hFF90, 16'd310, 6'b000010, 16'd198);
        add(16'hFF90, 16'd310, 6'b000000, 16'h0110);
        add(16'hFF90, 16'd310, 6'b010101, 16'hFFB6);
        add(16'hFF90, 16'd310, 6'b001111, 16'd112);
        add(16'd112, 16'hFECA, 6'b000010, 16'hFF3A);
        add(16'd112, 16'hFECA, 6'b010011, 16'd422);
        add(16'hFF90, 16'hFECA, 6'b000010, 16'hFE5A);
        add(16'hFF90, 16'hFECA, 6'b010011, 16'd198);
        add(16'hFFFF, 16'd0, 6'b011111, 16'h0000);
        add(16'h7FFF, 16'd0, 6'b011111, 16'h8000);

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.opr = '0;
        repeat (2) @(negedge clk);
        chk("reset.out", 32'(bus.out), 32'h0);
        chk("reset.zr", 32'(bus.zr), 32'h1);
        chk("reset.ng", 32'(bus.ng), 32'h0);
        chk("reset.out_valid", 32'(bus.out_valid), 32'h0);
        rst = 1'b0;

        // Back-to-back: drive vector i while checking vector i-1.
        for (int i = 0; i <= vecs.size(); i++) begin
            if (i > 0) begin
                @(negedge clk);
                chk($sformatf("vec%0d.out", i - 1), 32'(bus.out), 32'(vecs[i-1].exp));
                chk($sformatf("vec%0d.valid", i - 1), 32'(bus.out_valid), 32'h1);
            end
            if (i < vecs.size()) begin
                bus.a = vecs[i].a;
                bus.b = vecs[i].b;
                bus.opr = vecs[i].op;
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
        end

        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold.out", 32'(bus.out), 32'h8000);
            chk("hold.ng", 32'(bus.ng), 32'h1);
            chk("hold.zr", 32'(bus.zr), 32'h0);
            chk("hold.out_valid", 32'(bus.out_valid), 32'h0);
        end

        rst = 1'b1;
        bus.a = 16'd5;
        bus.b = 16'd7;
        bus.opr = 6'b001100;
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("rst_prio.out", 32'(bus.out), 32'h0);
        chk("rst_prio.zr", 32'(bus.zr), 32'h1);
        chk("rst_prio.ng", 32'(bus.ng), 32'h0);
        chk("rst_prio.out_valid", 32'(bus.out_valid), 32'h0);

        rst = 1'b0;
        bus.opr = 6'b000010;
        @(negedge clk);
        chk("first.out", 32'(bus.out), 32'd12);
        chk("first.out_valid", 32'(bus.out_valid), 32'h1);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("first.drop_valid", 32'(bus.out_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
